// File: rtl/alu_rr_arbiter.sv
// Shares one 64-bit ALU among NREQ requesters: round-robin issue with grant lock, and an
// in-order tag FIFO that routes each result back to its issuer. Define ALU_ARB_STATS_EN for counters.
module alu_rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int OUTST = 2
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NREQ-1:0]    req_valid_i,
  output logic [NREQ-1:0]    req_ready_o,
  input  logic [NREQ*64-1:0] req_in1_i,
  input  logic [NREQ*64-1:0] req_in2_i,
  input  logic [NREQ*3-1:0]  req_op_i,
  output logic [NREQ-1:0]    rsp_valid_o,
  input  logic [NREQ-1:0]    rsp_ready_i,
  output logic [63:0]        rsp_res_o,
  output logic [63:0]        alu_in1_o,
  output logic [63:0]        alu_in2_o,
  output logic [2:0]         alu_op_o,
  output logic               alu_in_valid_o,
  input  logic               alu_in_ready_i,
  input  logic [63:0]        alu_res_i,
  input  logic               alu_out_valid_i,
  output logic               alu_out_ready_o
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [NREQ*32-1:0] stat_grants_o,
  output logic [31:0]        stat_stall_o
`endif
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PW  = (OUTST > 1) ? $clog2(OUTST) : 1;
  localparam int CW  = $clog2(OUTST + 1);

  typedef enum logic [0:0] {
    ST_ARB  = 1'b0,
    ST_LOCK = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] lock_id_q, lock_id_d;
  logic [IDW-1:0] tag_q [OUTST];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;

  logic           win_found_s;
  logic [IDW-1:0] win_id_s;
  logic [IDW-1:0] sel_id_s;
  logic           issue_s;
  logic           accept_s;
  logic           full_s;
  logic           has_data_s;
  logic           pop_s;
  logic [IDW-1:0] head_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    return (ptr == PW'(OUTST - 1)) ? '0 : ptr + PW'(1);
  endfunction

  // Round-robin search: first valid requester at or after rr_ptr_q, wrapping.
  always_comb begin
    logic [IDW-1:0] cand;
    logic           hit;
    cand        = '0;
    hit         = 1'b0;
    win_found_s = 1'b0;
    win_id_s    = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand        = IDW'((int'(rr_ptr_q) + i) % NREQ);
      hit         = req_valid_i[cand] & ~win_found_s;
      win_id_s    = hit ? cand : win_id_s;
      win_found_s = win_found_s | hit;
    end
  end

  assign full_s   = (count_q == CW'(OUTST));
  assign sel_id_s = (state_q == ST_LOCK) ? lock_id_q : win_id_s;

  // Operand mux from the selected requester.
  always_comb begin
    alu_in1_o = '0;
    alu_in2_o = '0;
    alu_op_o  = '0;
    for (int k = 0; k < NREQ; k++) begin
      alu_in1_o = alu_in1_o | ({64{sel_id_s == IDW'(k)}} & req_in1_i[k*64 +: 64]);
      alu_in2_o = alu_in2_o | ({64{sel_id_s == IDW'(k)}} & req_in2_i[k*64 +: 64]);
      alu_op_o  = alu_op_o  | ({3{sel_id_s == IDW'(k)}}  & req_op_i[k*3 +: 3]);
    end
  end

  // Issue FSM: next state, lock capture and round-robin pointer update.
  always_comb begin
    state_d   = state_q;
    lock_id_d = lock_id_q;
    rr_ptr_d  = rr_ptr_q;
    issue_s   = 1'b0;
    accept_s  = 1'b0;
    case (state_q)
      ST_ARB:  issue_s = win_found_s & ~full_s;
      ST_LOCK: issue_s = req_valid_i[lock_id_q] & ~full_s;
      default: issue_s = 1'b0;
    endcase
    issue_s  = issue_s & rstn;
    accept_s = issue_s & alu_in_ready_i;
    case (state_q)
      ST_ARB: begin
        if (issue_s && !alu_in_ready_i) begin
          state_d   = ST_LOCK;
          lock_id_d = win_id_s;
        end else begin
          state_d   = ST_ARB;
        end
      end
      ST_LOCK: begin
        // A withdrawn request also releases the lock so the port cannot deadlock.
        if (accept_s || !req_valid_i[lock_id_q]) begin
          state_d = ST_ARB;
        end else begin
          state_d = ST_LOCK;
        end
      end
      default: state_d = ST_ARB;
    endcase
    if (accept_s) begin
      rr_ptr_d = (sel_id_s == IDW'(NREQ - 1)) ? '0 : sel_id_s + IDW'(1);
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  assign alu_in_valid_o = issue_s;

  // Return path: the FIFO head owns the result bus; an empty FIFO ignores stray results.
  assign has_data_s      = (count_q != '0);
  assign head_s          = tag_q[rd_ptr_q];
  assign alu_out_ready_o = rstn & has_data_s & rsp_ready_i[head_s];
  assign pop_s           = alu_out_valid_i & alu_out_ready_o;
  assign rsp_res_o       = alu_res_i;

  for (genvar k = 0; k < NREQ; k++) begin : g_port
    assign req_ready_o[k] = accept_s & (sel_id_s == IDW'(k));
    assign rsp_valid_o[k] = rstn & alu_out_valid_i & has_data_s & (head_s == IDW'(k));
  end

  // Tag FIFO pointer and occupancy update.
  always_comb begin
    wr_ptr_d = accept_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_s ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    case ({accept_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= ST_ARB;
      rr_ptr_q  <= '0;
      lock_id_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      for (int i = 0; i < OUTST; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      lock_id_q <= lock_id_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      if (accept_s) begin
        tag_q[wr_ptr_q] <= sel_id_s;
      end
    end
  end

`ifdef ALU_ARB_STATS_EN
  logic [31:0] grant_cnt_q [NREQ];
  logic [31:0] stall_cnt_q;

  // Saturating per-requester grant counters and ALU stall counter.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int k = 0; k < NREQ; k++) begin
        grant_cnt_q[k] <= 32'd0;
      end
      stall_cnt_q <= 32'd0;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        if (accept_s && (sel_id_s == IDW'(k)) && (grant_cnt_q[k] != 32'hFFFF_FFFF)) begin
          grant_cnt_q[k] <= grant_cnt_q[k] + 32'd1;
        end
      end
      if (alu_in_valid_o && !alu_in_ready_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  for (genvar k = 0; k < NREQ; k++) begin : g_stat
    assign stat_grants_o[k*32 +: 32] = grant_cnt_q[k];
  end
  assign stat_stall_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Randomized scoreboard bench for alu_rr_arbiter: queue-based requesters, an in-order ALU
// model and a reference arbiter model; a separate monitor checks returned results.
`timescale 1ns/1ps
module tb_alu_rr_arbiter;
  localparam int NREQ  = 4;
  localparam int OUTST = 2;
  localparam int IDW   = 2;

  logic               clk = 1'b0;
  logic               rstn = 1'b0;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*64-1:0] req_in1;
  logic [NREQ*64-1:0] req_in2;
  logic [NREQ*3-1:0]  req_op;
  logic [NREQ-1:0]    rsp_valid;
  logic [NREQ-1:0]    rsp_ready;
  logic [63:0]        rsp_res;
  logic [63:0]        alu_in1;
  logic [63:0]        alu_in2;
  logic [2:0]         alu_op;
  logic               alu_in_valid;
  logic               alu_in_ready;
  logic [63:0]        alu_res;
  logic               alu_out_valid;
  logic               alu_out_ready;
`ifdef ALU_ARB_STATS_EN
  logic [NREQ*32-1:0] stat_grants;
  logic [31:0]        stat_stall;
`endif

  alu_rr_arbiter #(.NREQ(NREQ), .OUTST(OUTST)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_in1_i(req_in1), .req_in2_i(req_in2), .req_op_i(req_op),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_res_o(rsp_res),
    .alu_in1_o(alu_in1), .alu_in2_o(alu_in2), .alu_op_o(alu_op),
    .alu_in_valid_o(alu_in_valid), .alu_in_ready_i(alu_in_ready),
    .alu_res_i(alu_res), .alu_out_valid_i(alu_out_valid), .alu_out_ready_o(alu_out_ready)
`ifdef ALU_ARB_STATS_EN
    , .stat_grants_o(stat_grants), .stat_stall_o(stat_stall)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] a; logic [63:0] b; logic [2:0] op; } op_t;
  typedef struct { int id; logic [63:0] res; } exp_t;
  typedef struct { logic [63:0] res; int rdy; } pipe_t;

  op_t   rq [NREQ][$];
  exp_t  sb_q[$];
  pipe_t pipe_q[$];
  int    m_tags[$];
  int    grant_log[$];
  int    exp_log[$];
  int    m_ptr = 0;
  int    m_lock = -1;
  int    cyc = 0;
  int    n_vec = 0;
  int    n_err = 0;
  int    grants [NREQ];
  int    stall_n = 0;
  bit    rst_hold = 1'b1;
  bit    spur = 1'b0;
  int unsigned alu_rdy_pct = 100;
  int unsigned alu_lat_max = 0;
  int unsigned rsp_pct [NREQ];

  function automatic logic [63:0] alu_fn(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return a << b[5:0];
      3'd6:    return a >> b[5:0];
      default: return ~a;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_op(input int k, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    op_t o;
    o.a = a; o.b = b; o.op = op;
    rq[k].push_back(o);
  endtask

  task automatic drive();
    rstn = ~rst_hold;
    for (int k = 0; k < NREQ; k++) begin
      if (rq[k].size() > 0) begin
        req_valid[k]         = 1'b1;
        req_in1[k*64 +: 64]  = rq[k][0].a;
        req_in2[k*64 +: 64]  = rq[k][0].b;
        req_op[k*3 +: 3]     = rq[k][0].op;
      end else begin
        req_valid[k]         = 1'b0;
        req_in1[k*64 +: 64]  = {$urandom, $urandom};
        req_in2[k*64 +: 64]  = {$urandom, $urandom};
        req_op[k*3 +: 3]     = 3'($urandom_range(7));
      end
      rsp_ready[k] = ($urandom_range(99) < rsp_pct[k]);
    end
    alu_in_ready = ($urandom_range(99) < alu_rdy_pct);
    if (pipe_q.size() > 0 && pipe_q[0].rdy <= cyc) begin
      alu_out_valid = 1'b1;
      alu_res       = pipe_q[0].res;
    end else if (spur && pipe_q.size() == 0) begin
      alu_out_valid = 1'b1;
      alu_res       = {$urandom, $urandom};
    end else begin
      alu_out_valid = 1'b0;
      alu_res       = {$urandom, $urandom};
    end
  endtask

  // Reference model: grant rule, lock, FIFO occupancy and ALU behaviour.
  task automatic model_check();
    int exp_id;
    bit exp_v, acc, exp_ordy, pop;
    op_t o;
    logic [63:0] r;
    exp_t e;
    pipe_t p;
    if (!rstn) begin
      chk("rst_alu_in_valid", 64'(alu_in_valid), 64'd0);
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_alu_out_ready", 64'(alu_out_ready), 64'd0);
      m_ptr = 0; m_lock = -1; stall_n = 0;
      m_tags.delete(); pipe_q.delete(); sb_q.delete(); grant_log.delete();
      for (int k = 0; k < NREQ; k++) grants[k] = 0;
      return;
    end
    if (m_lock >= 0 && rq[m_lock].size() == 0) m_lock = -1;
    exp_id = m_lock;
    if (exp_id < 0) begin
      for (int i = 0; i < NREQ; i++) begin
        if (exp_id < 0 && rq[(m_ptr + i) % NREQ].size() > 0) exp_id = (m_ptr + i) % NREQ;
      end
    end
    exp_v = (exp_id >= 0) && (m_tags.size() < OUTST);
    acc   = exp_v && alu_in_ready;
    chk("alu_in_valid", 64'(alu_in_valid), 64'(exp_v));
    chk("req_ready", 64'(req_ready), acc ? (64'd1 << exp_id) : 64'd0);
    if (exp_v) begin
      chk("alu_in1", alu_in1, rq[exp_id][0].a);
      chk("alu_in2", alu_in2, rq[exp_id][0].b);
      chk("alu_op", 64'(alu_op), 64'(rq[exp_id][0].op));
    end
    exp_ordy = (m_tags.size() > 0) && rsp_ready[IDW'(m_tags[0])];
    chk("alu_out_ready", 64'(alu_out_ready), 64'(exp_ordy));
    pop = exp_ordy && alu_out_valid;
    if (pop) begin
      void'(m_tags.pop_front());
      void'(pipe_q.pop_front());
    end
    if (exp_v && !alu_in_ready) stall_n++;
    if (acc) begin
      o = rq[exp_id].pop_front();
      r = alu_fn(o.op, o.a, o.b);
      e.id = exp_id; e.res = r;
      p.res = r; p.rdy = cyc + 1 + int'($urandom_range(alu_lat_max));
      m_tags.push_back(exp_id);
      sb_q.push_back(e);
      pipe_q.push_back(p);
      grant_log.push_back(exp_id);
      grants[exp_id]++;
      m_ptr  = (exp_id + 1) % NREQ;
      m_lock = -1;
    end else if (exp_v) begin
      m_lock = exp_id;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
    drive();
    @(negedge clk);
    #1;
    model_check();
  endtask

  // Response monitor: every result must go to the oldest outstanding issuer.
  always @(negedge clk) begin
    logic [NREQ-1:0] exp_rv;
    exp_rv = '0;
    if (rstn && alu_out_valid && sb_q.size() > 0) exp_rv = NREQ'(1) << sb_q[0].id;
    chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
    if (exp_rv != '0) begin
      chk("rsp_res", rsp_res, sb_q[0].res);
      if (rsp_ready[IDW'(sb_q[0].id)]) void'(sb_q.pop_front());
    end
  end

  function automatic bit busy();
    bit b;
    b = (m_tags.size() > 0) || (sb_q.size() > 0);
    for (int k = 0; k < NREQ; k++) b = b || (rq[k].size() > 0);
    return b;
  endfunction

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (busy() && n < budget) begin
      cycle();
      n++;
    end
    chk({name, "_drain_timeout"}, 64'(busy()), 64'd0);
  endtask

  task automatic chk_log(input string name);
    chk({name, "_count"}, 64'(grant_log.size()), 64'(exp_log.size()));
    for (int i = 0; i < exp_log.size() && i < grant_log.size(); i++) begin
      chk({name, "_order"}, 64'(grant_log[i]), 64'(exp_log[i]));
    end
    grant_log.delete();
    exp_log.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = '0; req_in1 = '0; req_in2 = '0; req_op = '0; rsp_ready = '0;
    alu_in_ready = 1'b0; alu_res = '0; alu_out_valid = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      rsp_pct[k] = 100;
      grants[k]  = 0;
    end

    // Reset with every requester valid, then round-robin with an always-ready ALU.
    for (int j = 0; j < 3; j++) begin
      for (int k = 0; k < NREQ; k++) begin
        if (k == 2 && j == 1) push_op(k, 3'd0, 64'd5, 64'd7);
        else push_op(k, 3'($urandom_range(7)), {$urandom, $urandom}, {$urandom, $urandom});
      end
    end
    rst_hold = 1'b1;
    repeat (2) cycle();
    rst_hold = 1'b0;
    cycle();
    chk("first_grant", 64'(req_ready), 64'h1);
    drain("rr", 200);
    for (int i = 0; i < 12; i++) exp_log.push_back(i % NREQ);
    chk_log("rr");

    // Lock: req1 stalled by the ALU, req0 appears meanwhile but must wait.
    alu_rdy_pct = 0;
    push_op(1, 3'd4, 64'hAAAA_0000_1111_2222, 64'h0F0F_0F0F_0F0F_0F0F);
    cycle();
    push_op(0, 3'd0, 64'd100, 64'd1);
    cycle();
    cycle();
    chk("lock_in1", alu_in1, 64'hAAAA_0000_1111_2222);
    alu_rdy_pct = 100;
    drain("lock", 50);
    exp_log.push_back(1); exp_log.push_back(0);
    chk_log("lock");

    // Backpressure: req0's result held while the FIFO fills.
    rsp_pct[0] = 0;
    push_op(0, 3'd1, 64'd10, 64'd3);
    cycle();
    push_op(1, 3'd0, 64'd1, 64'd2);
    push_op(2, 3'd0, 64'd3, 64'd4);
    repeat (4) cycle();
    chk("bp_rsp_valid", 64'(rsp_valid), 64'h1);
    chk("bp_rsp_res", rsp_res, 64'd7);
    chk("bp_full_block", 64'(alu_in_valid), 64'd0);
    rsp_pct[0] = 100;
    drain("bp", 50);
    exp_log.push_back(0); exp_log.push_back(1); exp_log.push_back(2);
    chk_log("bp");

    // Wrap: pointer at 3, only req3 and req0 valid.
    push_op(2, 3'd2, 64'hFF, 64'h0F);
    drain("wrap_pre", 20);
    push_op(3, 3'd5, 64'd1, 64'd4);
    push_op(0, 3'd6, 64'h100, 64'd4);
    drain("wrap", 20);
    exp_log.push_back(2); exp_log.push_back(3); exp_log.push_back(0);
    chk_log("wrap");

    // Stray ALU result with nothing outstanding.
    spur = 1'b1;
    repeat (3) begin
      cycle();
      chk("spur_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("spur_out_ready", 64'(alu_out_ready), 64'd0);
    end
    spur = 1'b0;

    // Randomized traffic with ALU and response backpressure.
    alu_rdy_pct = 60;
    alu_lat_max = 3;
    for (int c = 0; c < 1500; c++) begin
      if (c % 200 == 0) begin
        for (int k = 0; k < NREQ; k++) rsp_pct[k] = $urandom_range(100, 20);
      end
      for (int k = 0; k < NREQ; k++) begin
        if (rq[k].size() < 2 && $urandom_range(99) < 40)
          push_op(k, 3'($urandom_range(7)), {$urandom, $urandom}, {$urandom, $urandom});
      end
      cycle();
    end
    alu_rdy_pct = 100;
    for (int k = 0; k < NREQ; k++) rsp_pct[k] = 100;
    drain("rand", 300);
`ifdef ALU_ARB_STATS_EN
    for (int k = 0; k < NREQ; k++) chk("stat_grants", 64'(stat_grants[k*32 +: 32]), 64'(grants[k]));
    chk("stat_stall", 64'(stat_stall), 64'(stall_n));
`endif

    // Mid-operation reset with two results outstanding.
    alu_lat_max = 0;
    for (int k = 0; k < NREQ; k++) rsp_pct[k] = 0;
    push_op(0, 3'd0, 64'd1, 64'd1);
    push_op(1, 3'd0, 64'd2, 64'd2);
    push_op(2, 3'd0, 64'd3, 64'd3);
    repeat (3) cycle();
    chk("mid_full_block", 64'(alu_in_valid), 64'd0);
    for (int k = 0; k < NREQ; k++) rq[k].delete();
    rst_hold = 1'b1;
    repeat (2) cycle();
    rst_hold = 1'b0;
    for (int k = 0; k < NREQ; k++) rsp_pct[k] = 100;
    spur = 1'b1;
    repeat (3) begin
      cycle();
      chk("post_rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("post_rst_out_ready", 64'(alu_out_ready), 64'd0);
    end
    spur = 1'b0;
`ifdef ALU_ARB_STATS_EN
    for (int k = 0; k < NREQ; k++) chk("post_rst_grants", 64'(stat_grants[k*32 +: 32]), 64'd0);
    chk("post_rst_stall", 64'(stat_stall), 64'd0);
`endif
    push_op(3, 3'd1, 64'd9, 64'd4);
    drain("post_rst", 20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
